// File: rtl/sysctrl_pkg.sv
// Shared definitions for the MCU<->FPGA system-control byte protocol:
// command codes and the host-side FSM states.
package sysctrl_pkg;

   localparam logic [7:0] CMD_STATUS  = 8'h00;
   localparam logic [7:0] CMD_LEDS    = 8'h01;
   localparam logic [7:0] CMD_COLOR   = 8'h02;
   localparam logic [7:0] CMD_BUTTONS = 8'h03;
   localparam logic [7:0] CMD_CONFIG  = 8'h04;
   localparam logic [7:0] CMD_INT     = 8'h05;
   localparam logic [7:0] CMD_INTSRC  = 8'h06;
   localparam logic [7:0] CMD_MENU    = 8'h08;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_GAP,
      ST_PAYLOAD,
      ST_FIN
   } state_e;

   typedef enum logic {
      OWN_USER,
      OWN_IRQ
   } owner_e;

endpackage

// File: rtl/sysctrl_host_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sysctrl_host.sv
// System-control protocol initiator: frames user commands toward a responder
// and autonomously polls interrupt status (CMD 5) while the IRQ line is low.
module sysctrl_host
   import sysctrl_pkg::*;
#(
   parameter int GAP      = 2,
   parameter bit AUTO_IRQ = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_cmd,
   input  logic [3:0] req_len,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       done,
   output logic [7:0] irq_status,
   output logic       irq_valid,
   output logic       data_in_strobe,
   output logic       data_in_start,
   output logic [7:0] data_in,
   input  logic [7:0] data_out,
   input  logic       int_out_n
);

   localparam int CW = $clog2(GAP + 1);

   state_e        state_q;
   owner_e        owner_q;
   logic [7:0]    cmd_q;
   logic [3:0]    len_q;
   logic [3:0]    bcnt_q;
   logic [CW-1:0] cnt_q;
   logic          pay_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          done_q;
   logic [7:0]    irq_status_q;
   logic          irq_valid_q;
   logic          int_sync;
   logic          irq_req;
   logic          pay_fire;

   sync2 #(.RST_VAL(1'b1)) u_int_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (int_out_n),
      .q_o   (int_sync)
   );

   assign irq_req  = AUTO_IRQ && !int_sync;
   assign pay_fire = (state_q == ST_PAYLOAD) && ((owner_q == OWN_IRQ) || tx_valid);

   // Strobes are decoded so a payload byte goes out in the same cycle tx_valid is seen.
   assign req_ready      = (state_q == ST_IDLE) && !irq_req && !reset;
   assign tx_ready       = (state_q == ST_PAYLOAD) && (owner_q == OWN_USER) && tx_valid;
   assign data_in_start  = (state_q == ST_START);
   assign data_in_strobe = (state_q == ST_START) || pay_fire;

   always_comb begin
      data_in = 8'h00;
      if (state_q == ST_START)
         data_in = cmd_q;
      else if (pay_fire && (owner_q == OWN_USER))
         data_in = tx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_USER;
         cmd_q        <= 8'h00;
         len_q        <= 4'd0;
         bcnt_q       <= 4'd0;
         cnt_q        <= '0;
         pay_q        <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         done_q       <= 1'b0;
         irq_status_q <= 8'h00;
         irq_valid_q  <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         irq_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               bcnt_q <= 4'd0;
               if (irq_req) begin
                  cmd_q   <= CMD_INT;
                  len_q   <= 4'd1;
                  owner_q <= OWN_IRQ;
                  state_q <= ST_START;
               end else if (req_valid) begin
                  cmd_q   <= req_cmd;
                  len_q   <= req_len;
                  owner_q <= OWN_USER;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               cnt_q   <= CW'(GAP);
               pay_q   <= 1'b0;
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  // Responder output has settled by the last gap cycle.
                  if (pay_q) begin
                     if (owner_q == OWN_USER) begin
                        rx_data_q  <= data_out;
                        rx_valid_q <= 1'b1;
                     end else begin
                        irq_status_q <= data_out;
                        irq_valid_q  <= 1'b1;
                     end
                  end
                  if (bcnt_q != len_q) begin
                     state_q <= ST_PAYLOAD;
                  end else begin
                     done_q  <= (owner_q == OWN_USER);
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (pay_fire) begin
                  bcnt_q  <= bcnt_q + 4'd1;
                  pay_q   <= 1'b1;
                  cnt_q   <= CW'(GAP);
                  state_q <= ST_GAP;
               end
            end
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign done       = done_q;
   assign irq_status = irq_status_q;
   assign irq_valid  = irq_valid_q;

endmodule

// File: tb/tb_sysctrl_host.sv
// Directed bench for sysctrl_host with a small behavioural system-control responder.
module tb_sysctrl_host;

   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_cmd = 8'h00;
   logic [3:0] req_len = 4'd0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       done;
   logic [7:0] irq_status;
   logic       irq_valid;
   logic       data_in_strobe;
   logic       data_in_start;
   logic [7:0] data_in;
   logic [7:0] data_out = 8'h00;
   logic       int_out_n;

   int errors = 0;
   int checks = 0;

   sysctrl_host #(.GAP(GAP), .AUTO_IRQ(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
      .irq_status(irq_status), .irq_valid(irq_valid),
      .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
      .data_out(data_out), .int_out_n(int_out_n)
   );

   always #5 clk = ~clk;

   // Responder model: CMD0 returns 5C 42 00, CMD3 A5, CMD4 'D' key sets floppy,
   // CMD5 returns pending and acks by payload mask; a read masks the line until acked.
   logic [7:0] r_cmd = 8'h00;
   logic [3:0] r_idx = 4'd0;
   logic [7:0] pending = 8'h00;
   logic [7:0] seen = 8'h00;
   logic [7:0] floppy = 8'h00;
   logic [7:0] key = 8'h00;
   logic [7:0] pend_set = 8'h00;
   logic       int_ovr = 1'b0;

   assign int_out_n = ~(int_ovr | (|(pending & ~seen)));

   always @(posedge clk) begin
      if (pend_set != 8'h00) pending <= pending | pend_set;
      if (data_in_strobe) begin
         if (data_in_start) begin
            r_cmd    <= data_in;
            r_idx    <= 4'd0;
            data_out <= 8'h00;
         end else begin
            r_idx <= r_idx + 4'd1;
            case (r_cmd)
               8'h00: data_out <= (r_idx == 4'd0) ? 8'h5C : (r_idx == 4'd1) ? 8'h42 : 8'h00;
               8'h03: data_out <= 8'hA5;
               8'h04: begin
                  data_out <= 8'h00;
                  if (r_idx == 4'd0) key <= data_in;
                  else if (key == 8'h44) floppy <= data_in;
               end
               8'h05: begin
                  data_out <= pending;
                  pending  <= pending & ~data_in;
                  seen     <= pending & ~data_in;
               end
               default: data_out <= 8'h00;
            endcase
         end
      end
   end

   // Payload feeder: bytes with a per-byte stall measured from the previous pop.
   logic [7:0] txq[$];
   int         stq[$];
   int         stall = 0;
   bit         fire = 1'b0;

   always @(negedge clk) fire = tx_valid && tx_ready;

   always @(posedge clk) begin
      #2;
      if (fire && txq.size() > 0) begin
         void'(txq.pop_front());
         void'(stq.pop_front());
         if (stq.size() > 0) stall = stq[0];
      end else if (stall > 0) begin
         stall--;
      end
      if (txq.size() > 0 && stall == 0) begin
         tx_valid = 1'b1;
         tx_data  = txq[0];
      end else begin
         tx_valid = 1'b0;
         tx_data  = 8'h00;
      end
   end

   // Monitor
   int         cyc = 0;
   int         strobe_t[$];
   logic [7:0] strobe_d[$];
   bit         strobe_s[$];
   logic [7:0] rx_q[$];
   logic [7:0] irq_q[$];
   int         ndone = 0;
   int         done_t = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (data_in_strobe) begin
         strobe_t.push_back(cyc);
         strobe_d.push_back(data_in);
         strobe_s.push_back(data_in_start);
      end
      if (rx_valid) rx_q.push_back(rx_data);
      if (irq_valid) irq_q.push_back(irq_status);
      if (done) begin
         ndone++;
         done_t = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      strobe_t.delete(); strobe_d.delete(); strobe_s.delete();
      rx_q.delete(); irq_q.delete();
      ndone = 0; done_t = 0;
   endtask

   task automatic load_tx(input logic [7:0] b, input int st);
      txq.push_back(b);
      stq.push_back(st);
   endtask

   task automatic send_req(input logic [7:0] cmd, input logic [3:0] len, output bit ok);
      req_cmd = cmd; req_len = len; req_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (ndone > 0) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic wait_irq(input int n0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (irq_q.size() > n0) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks++;
      if ({req_ready, tx_ready, rx_valid, done, irq_valid, data_in_strobe, data_in_start} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {req_ready, tx_ready, rx_valid, done, irq_valid, data_in_strobe, data_in_start});
      end
      checks++;
      if ({data_in, rx_data, irq_status} !== 24'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 000000", {data_in, rx_data, irq_status});
      end
      reset = 1'b0;
      tick(3);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_cmd0(input string tag);
      bit ok, okd;
      logic [7:0] exp_rx [3];
      exp_rx[0] = 8'h5C; exp_rx[1] = 8'h42; exp_rx[2] = 8'h00;
      clear_mon();
      for (int i = 0; i < 3; i++) load_tx(8'h00, 0);
      send_req(8'h00, 4'd3, ok);
      wait_done(okd);
      tick(2);
      checks++;
      if (!(ok && okd) || ndone != 1) begin
         errors++;
         $display("FAIL %s_done: accepted=%0b done=%0d want accepted=1 done=1", tag, ok, ndone);
      end
      checks++;
      if (rx_q.size() != 3) begin
         errors++;
         $display("FAIL %s_rx_count: got %0d want 3", tag, rx_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_q[i] !== exp_rx[i]) begin
               errors++;
               $display("FAIL %s_rx%0d: got %h want %h", tag, i, rx_q[i], exp_rx[i]);
            end
         end
      end
      checks++;
      if (strobe_t.size() != 4) begin
         errors++;
         $display("FAIL %s_strobes: got %0d want 4", tag, strobe_t.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (strobe_t[i] - strobe_t[i-1] != GAP + 1 || strobe_s[i] !== 1'b0) begin
               errors++;
               $display("FAIL %s_spacing%0d: got %0d start=%0b want %0d start=0", tag, i,
                        strobe_t[i] - strobe_t[i-1], strobe_s[i], GAP + 1);
            end
         end
         checks++;
         if (strobe_s[0] !== 1'b1 || strobe_d[0] !== 8'h00) begin
            errors++;
            $display("FAIL %s_start: got start=%0b byte=%h want 1/00", tag, strobe_s[0], strobe_d[0]);
         end
      end
   endtask

   task automatic test_stall();
      bit ok, okd;
      clear_mon();
      load_tx(8'h44, 0);
      load_tx(8'h03, GAP + 5);
      send_req(8'h04, 4'd2, ok);
      wait_done(okd);
      tick(2);
      checks++;
      if (!(ok && okd) || floppy !== 8'h03) begin
         errors++;
         $display("FAIL stall_floppy: got %h done=%0b want 03 done=1", floppy, okd);
      end
      checks++;
      if (strobe_t.size() != 3) begin
         errors++;
         $display("FAIL stall_strobes: got %0d want 3", strobe_t.size());
      end else begin
         checks++;
         if (strobe_t[1] - strobe_t[0] != GAP + 1 || strobe_t[2] - strobe_t[1] != GAP + 6) begin
            errors++;
            $display("FAIL stall_spacing: got %0d,%0d want %0d,%0d", strobe_t[1] - strobe_t[0],
                     strobe_t[2] - strobe_t[1], GAP + 1, GAP + 6);
         end
      end
      checks++;
      if (rx_q.size() != 2) begin
         errors++;
         $display("FAIL stall_rx_count: got %0d want 2", rx_q.size());
      end
   endtask

   task automatic test_irq_priority();
      bit early = 1'b0;
      bit acc = 1'b0;
      bit okd;
      clear_mon();
      load_tx(8'h04, 0);
      int_ovr = 1'b1;
      pend_set = 8'h04;
      tick(1);
      pend_set = 8'h00;
      tick(1);
      req_cmd = 8'h05; req_len = 4'd1; req_valid = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL irq_prio_ready: got %b want 0", req_ready);
      end
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_ready) early = 1'b1;
         if (irq_q.size() >= 2) break;
      end
      checks++;
      if (early || irq_q.size() < 2 || ndone != 0) begin
         errors++;
         $display("FAIL irq_holdoff: early=%0b polls=%0d done=%0d want 0/2/0", early, irq_q.size(), ndone);
      end else begin
         checks++;
         if (irq_q[0] !== 8'h04 || irq_q[1] !== 8'h04) begin
            errors++;
            $display("FAIL irq_status: got %h,%h want 04,04", irq_q[0], irq_q[1]);
         end
      end
      int_ovr = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (req_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_done(okd);
      tick(2);
      checks++;
      if (!(acc && okd) || rx_q.size() != 1) begin
         errors++;
         $display("FAIL irq_user_after: accepted=%0b done=%0b rx=%0d want 1/1/1", acc, okd, rx_q.size());
      end else begin
         checks++;
         if (rx_q[0] !== 8'h04 || pending !== 8'h00) begin
            errors++;
            $display("FAIL irq_ack: rx=%h pending=%h want 04/00", rx_q[0], pending);
         end
      end
   endtask

   task automatic test_coldboot_ack();
      bit oki, ok, okd;
      int n;
      clear_mon();
      pend_set = 8'h01;
      tick(1);
      pend_set = 8'h00;
      wait_irq(0, oki);
      checks++;
      if (!oki || irq_q[0] !== 8'h01) begin
         errors++;
         $display("FAIL cold_poll: seen=%0b status=%h want 1/01", oki, oki ? irq_q[0] : 8'hxx);
      end
      load_tx(8'h01, 0);
      send_req(8'h05, 4'd1, ok);
      wait_done(okd);
      tick(2);
      checks++;
      if (!(ok && okd) || pending !== 8'h00 || rx_q.size() != 1) begin
         errors++;
         $display("FAIL cold_ack: done=%0b pending=%h rx=%0d want 1/00/1", okd, pending, rx_q.size());
      end
      n = irq_q.size();
      tick(30);
      checks++;
      if (irq_q.size() != n || int_out_n !== 1'b1) begin
         errors++;
         $display("FAIL cold_no_repoll: polls=%0d int_n=%b want %0d/1", irq_q.size(), int_out_n, n);
      end
   endtask

   task automatic test_len0();
      bit ok, okd;
      clear_mon();
      send_req(8'h08, 4'd0, ok);
      wait_done(okd);
      tick(3);
      checks++;
      if (strobe_t.size() != 1 || !(ok && okd)) begin
         errors++;
         $display("FAIL len0_strobes: got %0d done=%0b want 1/1", strobe_t.size(), okd);
      end else begin
         checks++;
         if (strobe_s[0] !== 1'b1 || strobe_d[0] !== 8'h08 || done_t - strobe_t[0] != GAP + 1) begin
            errors++;
            $display("FAIL len0_frame: start=%0b byte=%h done_delay=%0d want 1/08/%0d",
                     strobe_s[0], strobe_d[0], done_t - strobe_t[0], GAP + 1);
         end
      end
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL len0_rx: got %0d want 0", rx_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int ns = 0;
      clear_mon();
      for (int i = 0; i < 3; i++) load_tx(8'h00, 0);
      send_req(8'h00, 4'd3, ok);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (data_in_strobe) ns++;
         if (ns == 4) break;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ns != 4 || {req_ready, tx_ready, rx_valid, done, irq_valid, data_in_strobe, data_in_start,
                      data_in, rx_data, irq_status} !== 31'h0) begin
         errors++;
         $display("FAIL midreset_out: strobes=%0d outs=%h want 4/0", ns,
                  {req_ready, tx_ready, rx_valid, done, irq_valid, data_in_strobe, data_in_start,
                   data_in, rx_data, irq_status});
      end
      tick(2);
      txq.delete(); stq.delete();
      reset = 1'b0;
      tick(6);
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL midreset_done: got %0d want 0", ndone);
      end
      test_cmd0("after_reset");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cmd0("cmd0");
      test_stall();
      test_irq_priority();
      test_coldboot_ack();
      test_len0();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
